ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host frame receiver with an output FIFO. It replaces the keyboard-clocked register with a design clocked by sysClock. The PS/2 clock and data pins are synchronised and oversampled, and the PS/2 clock falling edges are detected on sysClock. Each frame is checked for start, parity and stop bits and for timeout, then valid bytes are buffered for the decoder through a valid/pop interface.

---
 rtl/ps2_rx_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver on sysClock with start/parity/stop/timeout checking
// and a show-ahead FIFO presenting received bytes to the decoder through a valid/pop handshake.
module ps2_rx_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 1,
  parameter int ODD_PARITY     = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          sysClock,
  input  logic                          sysReset,
  input  logic                          inKeyClk,
  input  logic                          regInData,
  input  logic                          popReq,
  output logic [DATA_BITS-1:0]          outData,
  output logic                          outValid,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          parityErr,
  output logic                          frameErr,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BC_W  = $clog2(DATA_BITS) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic parityOk(input logic [DATA_BITS-1:0] d, input logic p);
    logic ones;
    ones = (^d) ^ p;
    if (PARITY_EN == 0) return 1'b1;
    return (ODD_PARITY != 0) ? ones : ~ones;
  endfunction

  logic [SYNC_STAGES-1:0] clkSync, dataSync;
  logic                   clkPrev;
  logic                   fall, bitIn;

  state_t                 state, stateNxt;
  logic [BC_W-1:0]        bitCnt, bitCntNxt;
  logic [DATA_BITS-1:0]   shiftReg, shiftNxt;
  logic                   parBit, parNxt;
  logic [TO_W-1:0]        toCnt, toNxt;
  logic                   pushReq, pErrNxt, fErrNxt;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wrPtr, rdPtr;
  logic [CNT_W-1:0]       count;
  logic                   full, doPop, doPush, drop;

  // Stage: pin synchronisers, preset high so reset release never looks like a fall
  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) begin
      clkSync  <= '1;
      dataSync <= '1;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[SYNC_STAGES-2:0], inKeyClk};
      dataSync <= {dataSync[SYNC_STAGES-2:0], regInData};
      clkPrev  <= clkSync[SYNC_STAGES-1];
    end
  end

  assign fall  = clkPrev & ~clkSync[SYNC_STAGES-1];
  assign bitIn = dataSync[SYNC_STAGES-1];

  // Stage: frame FSM, advances on falls except for the inter-edge timeout abort
  always_comb begin
    stateNxt  = state;
    bitCntNxt = bitCnt;
    shiftNxt  = shiftReg;
    parNxt    = parBit;
    toNxt     = '0;
    pushReq   = 1'b0;
    pErrNxt   = 1'b0;
    fErrNxt   = 1'b0;
    if (state != IDLE && !fall) toNxt = toCnt + TO_W'(1);
    if (fall) begin
      case (state)
        IDLE: begin
          if (!bitIn) begin
            stateNxt  = DATA;
            bitCntNxt = '0;
          end
        end
        DATA: begin
          shiftNxt  = {bitIn, shiftReg[DATA_BITS-1:1]};
          bitCntNxt = bitCnt + BC_W'(1);
          if (bitCnt == BC_W'(DATA_BITS - 1)) stateNxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          parNxt   = bitIn;
          stateNxt = STOP;
        end
        STOP: begin
          stateNxt = IDLE;
          fErrNxt  = ~bitIn;
          pErrNxt  = ~parityOk(shiftReg, parBit);
          pushReq  = bitIn & parityOk(shiftReg, parBit);
        end
        default: stateNxt = IDLE;
      endcase
    end else if (state != IDLE && toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      stateNxt = IDLE;
      fErrNxt  = 1'b1;
      toNxt    = '0;
    end
  end

  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parBit    <= 1'b0;
      toCnt     <= '0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state     <= stateNxt;
      bitCnt    <= bitCntNxt;
      shiftReg  <= shiftNxt;
      parBit    <= parNxt;
      toCnt     <= toNxt;
      parityErr <= pErrNxt;
      frameErr  <= fErrNxt;
    end
  end

  // Stage: show-ahead FIFO; a pop frees the slot so a push into a full FIFO still lands
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign doPop  = popReq && (count != '0);
  assign doPush = pushReq && (!full || doPop);
  assign drop   = pushReq && full && !doPop;

  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count    <= count + CNT_W'(doPush) - CNT_W'(doPop);
      overflow <= drop;
    end
  end

  always_ff @(posedge sysClock) begin
    if (doPush) mem[wrPtr] <= shiftReg;
  end

  assign outValid  = (count != '0);
  assign outData   = outValid ? mem[rdPtr] : '0;
  assign fifoCount = count;

endmodule
